// File: rtl/dp_tcdm_rr_arbiter.sv
// Round-robin arbiter folding N_REQ TCDM requesters onto one master port.
// Grants are forwarded combinationally; an in-order owner FIFO routes each response back to its issuer.
module dp_tcdm_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       in_req,
  output logic [N_REQ-1:0]       in_gnt,
  input  logic [N_REQ-1:0][31:0] in_add,
  input  logic [N_REQ-1:0]       in_wen,
  input  logic [N_REQ-1:0][3:0]  in_be,
  input  logic [N_REQ-1:0][31:0] in_data,
  output logic [31:0]            in_r_data,
  output logic [N_REQ-1:0]       in_r_valid,
  output logic                   out_req,
  output logic [31:0]            out_add,
  output logic                   out_wen,
  output logic [3:0]             out_be,
  output logic [31:0]            out_data,
  input  logic                   out_gnt,
  input  logic [31:0]            out_r_data,
  input  logic                   out_r_valid,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    DEPTH   = (PW+1)'(FIFO_DEPTH);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  // Handshake: a transfer happens in every cycle with req && gnt; a requester holds req and
  // payload until then. r_valid is a one-cycle strobe with no back-pressure, one per transfer, in order.

  logic [IDW-1:0]   ptr_q, lock_id_q, winner;
  logic             lock_q, err_q;
  logic [IDW-1:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             empty, full, can_issue, any_req, push, pop;
  logic [N_REQ-1:0] win_oh, head_oh;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH);
  assign pop       = out_r_valid && !empty;
  assign can_issue = !full || out_r_valid;
  // A locked winner is followed even if it drops req, so the presented payload never switches.
  assign any_req   = lock_q ? in_req[lock_id_q] : |in_req;
  assign push      = out_req && out_gnt;
  assign win_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
  assign head_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << fifo_q[rd_ptr_q];
  assign busy_o    = !empty || out_req;
  assign err_o     = err_q;
  assign in_r_data = out_r_data;

  always_comb begin
    int  j;
    logic found;
    j      = 0;
    found  = 1'b0;
    winner = ptr_q;
    if (lock_q) begin
      winner = lock_id_q;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        j = int'(ptr_q) + i;
        if (j >= N_REQ) j = j - N_REQ;
        if (!found && in_req[j]) begin
          winner = j[IDW-1:0];
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_req    = can_issue && any_req;
    out_add    = '0;
    out_wen    = 1'b0;
    out_be     = '0;
    out_data   = '0;
    if (out_req) begin
      out_add  = in_add[winner];
      out_wen  = in_wen[winner];
      out_be   = in_be[winner];
      out_data = in_data[winner];
    end
    in_gnt     = push ? win_oh : '0;
    in_r_valid = pop ? head_oh : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push) begin
        ptr_q  <= (winner == LAST_ID) ? '0 : winner + 1'b1;
        lock_q <= 1'b0;
      end else if (out_req) begin
        lock_q    <= 1'b1;
        lock_id_q <= winner;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (out_r_valid && empty) err_q <= 1'b1;
    end
  end

  // Owner storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_dp_tcdm_rr_arbiter.sv
// Directed bench for dp_tcdm_rr_arbiter: fairness, lock, full FIFO, ordering, error and reset cases.
module tb_dp_tcdm_rr_arbiter;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       in_req, in_gnt, in_wen, in_r_valid;
  logic [N-1:0][31:0] in_add, in_data;
  logic [N-1:0][3:0]  in_be;
  logic [31:0]        in_r_data, out_add, out_data, out_r_data;
  logic               out_req, out_wen, out_gnt, out_r_valid, busy_o, err_o;
  logic [3:0]         out_be;

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_oh;
  logic [31:0]  exp_w;

  dp_tcdm_rr_arbiter #(.N_REQ(N), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
    .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .out_req(out_req), .out_add(out_add), .out_wen(out_wen), .out_be(out_be),
    .out_data(out_data), .out_gnt(out_gnt), .out_r_data(out_r_data),
    .out_r_valid(out_r_valid), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
    in_req      = req;
    out_gnt     = gnt;
    out_r_valid = rv;
    out_r_data  = rdata;
    #2;
  endtask

  initial begin
    rst         = 1'b1;
    in_req      = '0;
    out_gnt     = 1'b0;
    out_r_valid = 1'b0;
    out_r_data  = '0;
    for (int r = 0; r < N; r++) begin
      in_add[r]  = 32'h1000 + 32'(4 * r);
      in_wen[r]  = r[0];
      in_be[r]   = 4'(r + 1);
      in_data[r] = 32'hD000_0000 + 32'(r);
    end
    repeat (2) @(posedge clk);
    #3;
    chk("rst_out_req", 32'(out_req), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_gnt", 32'(in_gnt), 32'd0);
    chk("rst_rvalid", 32'(in_r_valid), 32'd0);
    rst = 1'b0;

    // Fairness: everyone requests, 1-cycle responses; seven grants leave ptr at 3.
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      drive((k < 7) ? 4'hF : 4'h0, 1'b1, (k > 0), 32'hA5A5_0000 + 32'(k));
      exp_oh = (k < 7) ? (4'b0001 << (k % 4)) : 4'b0000;
      chk("fair_gnt", 32'(in_gnt), 32'(exp_oh));
      exp_oh = (k > 0) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
      chk("fair_rvalid", 32'(in_r_valid), 32'(exp_oh));
      chk("fair_rdata", in_r_data, 32'hA5A5_0000 + 32'(k));
      if (k < 7) begin
        chk("fair_add", out_add, 32'h1000 + 32'(4 * (k % 4)));
        chk("fair_data", out_data, 32'hD000_0000 + 32'(k % 4));
        chk("fair_wen", 32'(out_wen), 32'(k % 2));
        chk("fair_be", 32'(out_be), 32'((k % 4) + 1));
      end
    end
    next_cycle();
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_add", out_add, 32'd0);

    // Lock: with ptr=3, requester 0 would beat 2 unless the stall lock holds.
    in_add[2] = 32'h100;
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      drive(4'b0100, 1'b0, 1'b0, 32'h0);
      chk("lock_req", 32'(out_req), 32'd1);
      chk("lock_add", out_add, 32'h100);
      chk("lock_gnt", 32'(in_gnt), 32'd0);
    end
    next_cycle();
    drive(4'b0101, 1'b0, 1'b0, 32'h0);
    chk("lock_hold_add", out_add, 32'h100);
    chk("lock_hold_gnt", 32'(in_gnt), 32'd0);
    next_cycle();
    drive(4'b0101, 1'b1, 1'b0, 32'h0);
    chk("lock_grant", 32'(in_gnt), 32'b0100);
    chk("lock_grant_add", out_add, 32'h100);
    exp_q.push_back(4'b0100);
    next_cycle();
    drive(4'b1001, 1'b1, 1'b0, 32'h0);
    chk("lock_next3", 32'(in_gnt), 32'b1000);
    exp_q.push_back(4'b1000);
    next_cycle();
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    chk("lock_next0", 32'(in_gnt), 32'b0001);
    exp_q.push_back(4'b0001);
    in_add[2] = 32'h1008;
    for (int d = 0; d < 3; d++) begin
      next_cycle();
      drive(4'h0, 1'b0, 1'b1, 32'hC0DE_0000 + 32'(d));
      exp_oh = exp_q.pop_front();
      chk("lock_rvalid", 32'(in_r_valid), 32'(exp_oh));
    end

    // Full FIFO: ptr=1, responses withheld.
    for (int g = 0; g < 4; g++) begin
      next_cycle();
      drive(4'hF, 1'b1, 1'b0, 32'h0);
      exp_oh = 4'b0001 << ((g + 1) % 4);
      chk("full_gnt", 32'(in_gnt), 32'(exp_oh));
      exp_q.push_back(exp_oh);
    end
    for (int w = 0; w < 2; w++) begin
      next_cycle();
      drive(4'hF, 1'b1, 1'b0, 32'h0);
      chk("full_req", 32'(out_req), 32'd0);
      chk("full_gnt0", 32'(in_gnt), 32'd0);
      chk("full_busy", 32'(busy_o), 32'd1);
    end
    next_cycle();
    drive(4'hF, 1'b1, 1'b1, 32'h5A5A);
    exp_oh = exp_q.pop_front();
    chk("full_pop_rvalid", 32'(in_r_valid), 32'(exp_oh));
    chk("full_pop_gnt", 32'(in_gnt), 32'b0010);
    exp_q.push_back(4'b0010);
    next_cycle();
    drive(4'hF, 1'b1, 1'b0, 32'h0);
    chk("full_still", 32'(out_req), 32'd0);
    for (int d = 0; d < 4; d++) begin
      next_cycle();
      drive(4'h0, 1'b0, 1'b1, 32'h0);
      exp_oh = exp_q.pop_front();
      chk("full_drain", 32'(in_r_valid), 32'(exp_oh));
    end
    next_cycle();
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    chk("full_idle_busy", 32'(busy_o), 32'd0);

    // Ordering: ptr=2, grants 1,3,1, responses five cycles later.
    next_cycle();
    drive(4'b0010, 1'b1, 1'b0, 32'h0);
    chk("ord_gnt1", 32'(in_gnt), 32'b0010);
    exp_q.push_back(4'b0010);
    next_cycle();
    drive(4'b1000, 1'b1, 1'b0, 32'h0);
    chk("ord_gnt3", 32'(in_gnt), 32'b1000);
    exp_q.push_back(4'b1000);
    next_cycle();
    drive(4'b0010, 1'b1, 1'b0, 32'h0);
    chk("ord_gnt1b", 32'(in_gnt), 32'b0010);
    exp_q.push_back(4'b0010);
    for (int w = 0; w < 2; w++) begin
      next_cycle();
      drive(4'h0, 1'b0, 1'b0, 32'h0);
      chk("ord_wait_busy", 32'(busy_o), 32'd1);
      chk("ord_wait_rvalid", 32'(in_r_valid), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      exp_w = 32'hA + 32'(i);
      next_cycle();
      drive(4'h0, 1'b0, 1'b1, exp_w);
      exp_oh = exp_q.pop_front();
      chk("ord_rvalid", 32'(in_r_valid), 32'(exp_oh));
      chk("ord_rdata", in_r_data, exp_w);
    end

    // Error: response with nothing outstanding.
    next_cycle();
    drive(4'h0, 1'b0, 1'b1, 32'hEE);
    chk("err_rvalid", 32'(in_r_valid), 32'd0);
    chk("err_not_yet", 32'(err_o), 32'd0);
    next_cycle();
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    chk("err_set", 32'(err_o), 32'd1);
    next_cycle();
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    chk("err_hold", 32'(err_o), 32'd1);
    next_cycle();
    rst = 1'b1;
    #2;
    chk("err_rst", 32'(err_o), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    chk("err_clear", 32'(err_o), 32'd0);

    // Reset mid-flight: two outstanding, ptr moved to 3, then reset.
    next_cycle();
    drive(4'b0010, 1'b1, 1'b0, 32'h0);
    chk("mid_gnt1", 32'(in_gnt), 32'b0010);
    next_cycle();
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    chk("mid_gnt2", 32'(in_gnt), 32'b0100);
    next_cycle();
    rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    chk("mid_busy", 32'(busy_o), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(4'hF, 1'b1, 1'b0, 32'h0);
    chk("mid_gnt_low", 32'(in_gnt), 32'b0001);
    chk("mid_busy_req", 32'(busy_o), 32'd1);
    next_cycle();
    drive(4'h0, 1'b0, 1'b1, 32'h77);
    chk("mid_rvalid", 32'(in_r_valid), 32'b0001);
    next_cycle();
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    chk("mid_idle", 32'(busy_o), 32'd0);
    chk("mid_err", 32'(err_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
